// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: shift modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shmode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions; the caller supplies the SRA fill bit.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 2,
    parameter int AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] word_i,
    input  shmode_e          mode_i,
    input  logic [AW-1:0]    amount_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] upper;

    // Right-type shifts: the upper half of the concatenation supplies the incoming bits.
    always_comb begin
        case (mode_i)
            SH_ROR:  upper = word_i;
            SH_SRA:  upper = {WIDTH{fill_i}};
            default: upper = '0;
        endcase
        if (mode_i == SH_SLL) begin
            word_o = word_i << amount_i;
        end else begin
            word_o = WIDTH'({upper, word_i} >> amount_i);
        end
    end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR by a variable amount, at most STEP positions per clock.
module shift_iter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 2,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_shift,
    input  logic [1:0]       ctrl_mode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int           AW     = $clog2(STEP + 1);
    localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   rem_q, rem_d;
    shmode_e          mode_q, mode_d;
    logic             fill_q, fill_d;
    logic             rdy_q, busy_q;
    logic [AW-1:0]    k;
    logic [WIDTH-1:0] step_out;

    // k = min(rem, STEP); STEP may equal WIDTH, hence the widened compare.
    assign k = ({1'b0, rem_q} < STEP_W) ? AW'(rem_q) : AW'(STEP);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .word_i   (work_q),
        .mode_i   (mode_q),
        .amount_i (k),
        .fill_i   (fill_q),
        .word_o   (step_out)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        case (state_q)
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - SHW'(k);
                if (rem_q == SHW'(k)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new start; DONE otherwise falls back to IDLE.
                state_d = ST_IDLE;
                if (ctrl_shift) begin
                    work_d  = data_operandA;
                    mode_d  = shmode_e'(ctrl_mode);
                    fill_d  = data_operandA[WIDTH-1];
                    rem_d   = ctrl_shiftamt;
                    state_d = (ctrl_shiftamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            rdy_q   <= (state_d == ST_DONE);
            busy_q  <= (state_d == ST_SHIFT);
        end
    end

    // Mode and fill bit are only meaningful while a shift is in flight.
    always_ff @(posedge clock) begin
        mode_q <= mode_d;
        fill_q <= fill_d;
    end

    assign data_result    = work_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule
